wb_ppfifo_2_mem: RTL and testbench

Drains a read-side Ping Pong FIFO into a double-buffered region of Wishbone-attached memory. It acts as the Wishbone master that writes each FIFO word to `base + ptr` of the active bank, and tracks a per-bank word count. When a bank fills, it reports the bank to the host and moves to the other bank. It sits between a streaming source (camera/ADC path via PPFIFO) and the memory arbiter, mirroring the memory-to-FIFO path in the opposite direction.

---
 rtl/wb_ppfifo_2_mem_pkg.sv | 23 ++
 rtl/wb_mem_bank_ptr.sv | 30 +++
 rtl/wb_ppfifo_2_mem.sv | 191 +++++++++++++++++++
 tb/tb_wb_ppfifo_2_mem.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ppfifo_2_mem_pkg.sv
// Shared definitions for the PPFIFO-to-Wishbone-memory drain block:
// controller state encodings and the fixed Wishbone byte select.
package wb_ppfifo_2_mem_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WAIT_BANK = 4'd1;
    localparam logic [3:0] ST_WAIT_FIFO = 4'd2;
    localparam logic [3:0] ST_LOAD      = 4'd3;
    localparam logic [3:0] ST_WRITE     = 4'd4;
    localparam logic [3:0] ST_BANK_DONE = 4'd5;

    typedef enum logic [3:0] {
        IDLE      = ST_IDLE,
        WAIT_BANK = ST_WAIT_BANK,
        WAIT_FIFO = ST_WAIT_FIFO,
        LOAD      = ST_LOAD,
        WRITE     = ST_WRITE,
        BANK_DONE = ST_BANK_DONE
    } state_t;

    localparam logic [3:0] MEM_SEL_DEFAULT = 4'hF;

endpackage

// File: rtl/wb_mem_bank_ptr.sv
// Per-bank word pointer: counts acknowledged writes, reports full/ready.
// An arm pulse clears the pointer and wins over a same-cycle increment.
module wb_mem_bank_ptr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_size,
    input  logic        i_new_data,
    input  logic        i_inc,
    output logic [31:0] o_ptr,
    output logic        o_full,
    output logic        o_ready
);

    logic [31:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 32'd0;
        end else if (i_new_data) begin
            r_ptr <= 32'd0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 32'd1;
        end
    end

    assign o_ptr   = r_ptr;
    assign o_full  = (r_ptr == i_size);
    assign o_ready = (r_ptr < i_size);

endmodule

// File: rtl/wb_ppfifo_2_mem.sv
// Wishbone master that drains a read-side ping-pong FIFO into two
// alternating memory banks, reporting each bank as it fills.
//
// state     | meaning
// IDLE      | disabled, bus idle
// WAIT_BANK | waiting for a bank with free space
// WAIT_FIFO | waiting for an active FIFO block with unread words
// LOAD      | capture FIFO word, pop it, launch the bus write
// WRITE     | write strobe out, waiting for ack
// BANK_DONE | bank filled, bus released, finish pulse out
module wb_ppfifo_2_mem
    import wb_ppfifo_2_mem_pkg::*;
#(
    parameter int ADDR_STRIDE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [31:0] i_memory_0_base,
    input  logic [31:0] i_memory_0_size,
    input  logic        i_memory_0_new_data,
    output logic [31:0] o_memory_0_count,
    output logic        o_memory_0_full,
    input  logic [31:0] i_memory_1_base,
    input  logic [31:0] i_memory_1_size,
    input  logic        i_memory_1_new_data,
    output logic [31:0] o_memory_1_count,
    output logic        o_memory_1_full,
    output logic        o_write_finished,
    output logic        o_finished_bank,
    output logic        o_mem_we,
    output logic        o_mem_stb,
    output logic        o_mem_cyc,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    input  logic        i_mem_ack,
    input  logic        i_ppfifo_rdy,
    output logic        o_ppfifo_act,
    input  logic [23:0] i_ppfifo_size,
    output logic        o_ppfifo_stb,
    input  logic [31:0] i_ppfifo_data
);

    localparam logic [31:0] STRIDE = 32'(ADDR_STRIDE);

    state_t      r_state;
    logic        r_active;
    logic [23:0] r_fcnt;
    logic        r_act;
    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [31:0] r_dat;
    logic        r_write_finished;
    logic        r_finished_bank;

    logic [31:0] w_ptr0, w_ptr1, w_ptr_act, w_size_act, w_base_act;
    logic        w_ready0, w_ready1, w_nd_act, w_ack, w_fills;

    assign w_ack = (r_state == WRITE) && i_mem_ack && r_stb;

    wb_mem_bank_ptr u_bank0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_size     (i_memory_0_size),
        .i_new_data (i_memory_0_new_data),
        .i_inc      (w_ack && !r_active),
        .o_ptr      (w_ptr0),
        .o_full     (o_memory_0_full),
        .o_ready    (w_ready0)
    );

    wb_mem_bank_ptr u_bank1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_size     (i_memory_1_size),
        .i_new_data (i_memory_1_new_data),
        .i_inc      (w_ack && r_active),
        .o_ptr      (w_ptr1),
        .o_full     (o_memory_1_full),
        .o_ready    (w_ready1)
    );

    assign w_ptr_act  = r_active ? w_ptr1 : w_ptr0;
    assign w_size_act = r_active ? i_memory_1_size : i_memory_0_size;
    assign w_base_act = r_active ? i_memory_1_base : i_memory_0_base;
    assign w_nd_act   = r_active ? i_memory_1_new_data : i_memory_0_new_data;
    // A re-arm landing on the final ack restarts the bank rather than finishing it.
    assign w_fills    = ((w_ptr_act + 32'd1) == w_size_act) && !w_nd_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_active         <= 1'b0;
            r_fcnt           <= 24'd0;
            r_act            <= 1'b0;
            r_cyc            <= 1'b0;
            r_stb            <= 1'b0;
            r_we             <= 1'b0;
            r_dat            <= 32'd0;
            r_write_finished <= 1'b0;
            r_finished_bank  <= 1'b0;
        end else begin
            r_write_finished <= 1'b0;

            // FIFO block ownership runs independently of the bus FSM.
            if (i_enable && i_ppfifo_rdy && !r_act) begin
                r_act  <= 1'b1;
                r_fcnt <= 24'd0;
            end else if (r_act && (r_fcnt == i_ppfifo_size)) begin
                r_act <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_cyc <= 1'b0;
                    r_stb <= 1'b0;
                    r_we  <= 1'b0;
                    if (i_enable) r_state <= WAIT_BANK;
                end
                WAIT_BANK: begin
                    if (!i_enable) begin
                        r_state <= IDLE;
                    end else if (w_ready0) begin
                        r_active <= 1'b0;
                        r_state  <= WAIT_FIFO;
                    end else if (w_ready1) begin
                        r_active <= 1'b1;
                        r_state  <= WAIT_FIFO;
                    end
                end
                WAIT_FIFO: begin
                    if (!i_enable) begin
                        r_cyc   <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_act && (r_fcnt < i_ppfifo_size)) begin
                        r_state <= LOAD;
                    end else begin
                        r_cyc <= 1'b0;
                    end
                end
                LOAD: begin
                    r_dat   <= i_ppfifo_data;
                    r_fcnt  <= r_fcnt + 24'd1;
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we    <= 1'b1;
                    r_state <= WRITE;
                end
                WRITE: begin
                    if (i_mem_ack && r_stb) begin
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        if (w_fills) begin
                            r_write_finished <= 1'b1;
                            r_finished_bank  <= r_active;
                            r_state          <= BANK_DONE;
                        end else if (!i_enable) begin
                            r_cyc   <= 1'b0;
                            r_state <= IDLE;
                        end else if (r_fcnt == i_ppfifo_size) begin
                            r_state <= WAIT_FIFO;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                BANK_DONE: begin
                    r_cyc   <= 1'b0;
                    r_state <= WAIT_BANK;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_memory_0_count = w_ptr0;
    assign o_memory_1_count = w_ptr1;
    assign o_write_finished = r_write_finished;
    assign o_finished_bank  = r_finished_bank;
    assign o_mem_we         = r_we;
    assign o_mem_stb        = r_stb;
    assign o_mem_cyc        = r_cyc;
    assign o_mem_sel        = MEM_SEL_DEFAULT;
    assign o_mem_adr        = w_base_act + (w_ptr_act * STRIDE);
    assign o_mem_dat        = r_dat;
    assign o_ppfifo_act     = r_act;
    assign o_ppfifo_stb     = (r_state == LOAD);

endmodule

// File: tb/tb_wb_ppfifo_2_mem.sv
// Bench for wb_ppfifo_2_mem: FIFO source and Wishbone slave models,
// with expected writes computed from a bank-filling reference loop.
module tb_wb_ppfifo_2_mem;

    localparam int STRIDE = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [31:0] i_memory_0_base, i_memory_0_size, i_memory_1_base, i_memory_1_size;
    logic        i_memory_0_new_data, i_memory_1_new_data;
    logic [31:0] o_memory_0_count, o_memory_1_count;
    logic        o_memory_0_full, o_memory_1_full;
    logic        o_write_finished, o_finished_bank;
    logic        o_mem_we, o_mem_stb, o_mem_cyc;
    logic [3:0]  o_mem_sel;
    logic [31:0] o_mem_adr, o_mem_dat;
    logic        i_mem_ack;
    logic        i_ppfifo_rdy;
    logic        o_ppfifo_act;
    logic [23:0] i_ppfifo_size;
    logic        o_ppfifo_stb;
    logic [31:0] i_ppfifo_data;

    always #5 clk = ~clk;

    wb_ppfifo_2_mem #(.ADDR_STRIDE(STRIDE)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_enable            (i_enable),
        .i_memory_0_base     (i_memory_0_base),
        .i_memory_0_size     (i_memory_0_size),
        .i_memory_0_new_data (i_memory_0_new_data),
        .o_memory_0_count    (o_memory_0_count),
        .o_memory_0_full     (o_memory_0_full),
        .i_memory_1_base     (i_memory_1_base),
        .i_memory_1_size     (i_memory_1_size),
        .i_memory_1_new_data (i_memory_1_new_data),
        .o_memory_1_count    (o_memory_1_count),
        .o_memory_1_full     (o_memory_1_full),
        .o_write_finished    (o_write_finished),
        .o_finished_bank     (o_finished_bank),
        .o_mem_we            (o_mem_we),
        .o_mem_stb           (o_mem_stb),
        .o_mem_cyc           (o_mem_cyc),
        .o_mem_sel           (o_mem_sel),
        .o_mem_adr           (o_mem_adr),
        .o_mem_dat           (o_mem_dat),
        .i_mem_ack           (i_mem_ack),
        .i_ppfifo_rdy        (i_ppfifo_rdy),
        .o_ppfifo_act        (o_ppfifo_act),
        .i_ppfifo_size       (i_ppfifo_size),
        .o_ppfifo_stb        (o_ppfifo_stb),
        .i_ppfifo_data       (i_ppfifo_data)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO source: current word is presented until the cycle after a pop.
    logic [31:0] blk[$];
    int          rd_idx   = 0;
    bit          pop_pend = 0;
    int          pop_cnt  = 0;

    always @(negedge clk) begin
        if (o_ppfifo_act) i_ppfifo_rdy = 1'b0;
        if (pop_pend) rd_idx++;
        i_ppfifo_data = (rd_idx < blk.size()) ? blk[rd_idx] : 32'hDEAD_BEEF;
        pop_pend = o_ppfifo_stb;
        if (o_ppfifo_stb) pop_cnt++;
    end

    // Wishbone slave with configurable ack latency and a log of accepted writes.
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          nd_on_ack = -1;
    bit          nd_chk    = 0;
    logic [31:0] wr_adr[$], wr_dat[$];

    always @(negedge clk) begin
        if (nd_chk) begin
            chk("count0_after_clear", o_memory_0_count, 32'd0);
            i_memory_0_new_data = 1'b0;
            nd_chk = 0;
        end
        if (o_mem_stb && o_mem_cyc && !i_mem_ack) begin
            if (wait_cnt >= ack_delay) begin
                i_mem_ack = 1'b1;
                wait_cnt  = 0;
                wr_adr.push_back(o_mem_adr);
                wr_dat.push_back(o_mem_dat);
                chk("we_with_stb", 32'(o_mem_we), 32'd1);
                if (nd_on_ack == wr_adr.size() - 1) begin
                    i_memory_0_new_data = 1'b1;
                    nd_chk    = 1;
                    nd_on_ack = -1;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            i_mem_ack = 1'b0;
            if (!o_mem_stb) wait_cnt = 0;
        end
    end

    // Bus stability while strobed, finish-pulse log, activity flags.
    logic [31:0] hold_adr, hold_dat;
    bit          holding  = 0;
    int          fin_q[$];
    int          fin_act[$];
    bit          act_seen = 0;
    bit          cyc_seen = 0;

    always @(negedge clk) begin
        if (o_mem_stb) begin
            if (holding) begin
                chk("adr_stable", o_mem_adr, hold_adr);
                chk("dat_stable", o_mem_dat, hold_dat);
            end else begin
                hold_adr = o_mem_adr;
                hold_dat = o_mem_dat;
                holding  = 1;
            end
        end else begin
            holding = 0;
        end
        if (o_write_finished) begin
            fin_q.push_back(int'(o_finished_bank));
            fin_act.push_back(int'(o_ppfifo_act));
        end
        if (o_ppfifo_act) act_seen = 1;
        if (o_mem_cyc) cyc_seen = 1;
    end

    task automatic chk_rst_out(input string p);
        chk({p, "_sel"},    32'(o_mem_sel), 32'hF);
        chk({p, "_cyc"},    32'(o_mem_cyc), 32'd0);
        chk({p, "_stb"},    32'(o_mem_stb), 32'd0);
        chk({p, "_we"},     32'(o_mem_we), 32'd0);
        chk({p, "_adr"},    o_mem_adr, 32'd0);
        chk({p, "_dat"},    o_mem_dat, 32'd0);
        chk({p, "_act"},    32'(o_ppfifo_act), 32'd0);
        chk({p, "_ppstb"},  32'(o_ppfifo_stb), 32'd0);
        chk({p, "_wfin"},   32'(o_write_finished), 32'd0);
        chk({p, "_fbank"},  32'(o_finished_bank), 32'd0);
        chk({p, "_count0"}, o_memory_0_count, 32'd0);
        chk({p, "_count1"}, o_memory_1_count, 32'd0);
        chk({p, "_full0"},  32'(o_memory_0_full), 32'd0);
        chk({p, "_full1"},  32'(o_memory_1_full), 32'd0);
    endtask

    // Reference: each word goes to the first bank with room, at base + ptr*stride.
    task automatic run_case(input string nm, input int s0, input int s1,
                            input logic [31:0] b0, input logic [31:0] b1,
                            input int nw, input logic [31:0] w0, input int dly,
                            input int nd_idx);
        int          p0 = 0;
        int          p1 = 0;
        int          cyc_n = 0;
        int          nwr = 0;
        logic [31:0] ea[$], ed[$], words[$];
        int          ef[$];

        @(posedge clk); #2;
        i_enable = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        i_memory_0_size = 32'(s0);
        i_memory_1_size = 32'(s1);
        i_memory_0_base = b0;
        i_memory_1_base = b1;
        ack_delay = dly;
        i_memory_0_new_data = 1'b1;
        i_memory_1_new_data = 1'b1;
        @(posedge clk); #2;
        i_memory_0_new_data = 1'b0;
        i_memory_1_new_data = 1'b0;

        for (int i = 0; i < nw; i++) words.push_back((w0 != 32'd0) ? w0 + 32'(i) : $urandom);
        foreach (words[i]) begin
            if (p0 < s0) begin
                ea.push_back(b0 + 32'(p0 * STRIDE));
                p0++;
                if (nwr == nd_idx) p0 = 0;
                else if (p0 == s0) ef.push_back(0);
            end else if (p1 < s1) begin
                ea.push_back(b1 + 32'(p1 * STRIDE));
                p1++;
                if (p1 == s1) ef.push_back(1);
            end else begin
                break;
            end
            ed.push_back(words[i]);
            nwr++;
        end

        wr_adr.delete(); wr_dat.delete(); fin_q.delete(); fin_act.delete();
        pop_cnt   = 0;
        nd_on_ack = nd_idx;
        blk       = words;
        rd_idx    = 0;
        i_ppfifo_size = 24'(nw);
        i_ppfifo_data = words[0];
        i_ppfifo_rdy  = 1'b1;
        i_enable      = 1'b1;

        while ((wr_adr.size() < ea.size() || fin_q.size() < ef.size()) && cyc_n < 2000) begin
            @(posedge clk);
            cyc_n++;
        end
        chk({nm, "_in_time"}, 32'(cyc_n < 2000), 32'd1);
        repeat (4) @(posedge clk);
        #2;

        chk({nm, "_nwrites"}, 32'(wr_adr.size()), 32'(ea.size()));
        chk({nm, "_npops"},   32'(pop_cnt), 32'(ea.size()));
        chk({nm, "_nfins"},   32'(fin_q.size()), 32'(ef.size()));
        for (int i = 0; i < ea.size(); i++) begin
            if (i < wr_adr.size()) begin
                chk($sformatf("%s_adr%0d", nm, i), wr_adr[i], ea[i]);
                chk($sformatf("%s_dat%0d", nm, i), wr_dat[i], ed[i]);
            end
        end
        for (int i = 0; i < ef.size(); i++) begin
            if (i < fin_q.size()) chk($sformatf("%s_finbank%0d", nm, i), 32'(fin_q[i]), 32'(ef[i]));
        end
        chk({nm, "_count0"}, o_memory_0_count, 32'(p0));
        chk({nm, "_count1"}, o_memory_1_count, 32'(p1));
        chk({nm, "_full0"},  32'(o_memory_0_full), 32'(p0 == s0));
        chk({nm, "_full1"},  32'(o_memory_1_full), 32'(p1 == s1));
        chk({nm, "_act_released"}, 32'(o_ppfifo_act), 32'd0);
    endtask

    initial begin
        int cyc_n;
        rst_n = 1'b0;
        i_enable = 1'b0;
        i_memory_0_base = 32'd0;
        i_memory_1_base = 32'd0;
        i_memory_0_size = 32'd4;
        i_memory_1_size = 32'd4;
        i_memory_0_new_data = 1'b0;
        i_memory_1_new_data = 1'b0;
        i_mem_ack = 1'b0;
        i_ppfifo_rdy = 1'b0;
        i_ppfifo_size = 24'd0;
        i_ppfifo_data = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk_rst_out("rst");
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk_rst_out("post_rst");

        run_case("single_bank", 4, 0, 32'h0, 32'h0, 4, 32'hA0, 0, -1);

        run_case("bank_switch", 2, 3, 32'h0, 32'h8_0000, 5, 32'd0, 0, -1);
        if (fin_act.size() > 0) chk("act_held_at_switch", 32'(fin_act[0]), 32'd1);
        else chk("act_held_at_switch_seen", 32'(fin_act.size()), 32'd1);

        run_case("slow_ack", 4, 2, 32'h100, 32'h200, 6, 32'd0, 5, -1);

        run_case("clear_on_ack", 4, 0, 32'h0, 32'h0, 5, 32'd0, 1, 0);

        // Reset while a write strobe is outstanding.
        @(posedge clk); #2;
        i_enable = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        i_memory_0_base = 32'h0;
        i_memory_0_size = 32'd4;
        i_memory_1_size = 32'd2;
        ack_delay = 5;
        i_memory_0_new_data = 1'b1;
        i_memory_1_new_data = 1'b1;
        @(posedge clk); #2;
        i_memory_0_new_data = 1'b0;
        i_memory_1_new_data = 1'b0;
        blk.delete();
        for (int i = 0; i < 4; i++) blk.push_back(32'h5500 + 32'(i));
        rd_idx = 0;
        i_ppfifo_size = 24'd4;
        i_ppfifo_data = blk[0];
        i_ppfifo_rdy = 1'b1;
        i_enable = 1'b1;
        cyc_n = 0;
        while (!o_mem_stb && cyc_n < 200) begin
            @(negedge clk);
            cyc_n++;
        end
        chk("rst_mid_stb_reached", 32'(o_mem_stb), 32'd1);
        #2;
        rst_n = 1'b0;
        i_enable = 1'b0;
        #1;
        chk_rst_out("rst_mid");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        i_ppfifo_rdy = 1'b1;
        act_seen = 0;
        cyc_seen = 0;
        pop_cnt = 0;
        repeat (10) @(posedge clk);
        #2;
        chk("idle_after_rst_cyc", 32'(cyc_seen), 32'd0);
        chk("idle_after_rst_act", 32'(act_seen), 32'd0);
        chk("idle_after_rst_pops", 32'(pop_cnt), 32'd0);
        i_ppfifo_rdy = 1'b0;

        for (int k = 0; k < 8; k++) begin
            int s0, s1, nw;
            s0 = int'($urandom_range(0, 5));
            s1 = int'($urandom_range(0, 5));
            if (s0 + s1 == 0) s1 = 1;
            nw = int'($urandom_range(1, s0 + s1));
            run_case($sformatf("rnd%0d", k), s0, s1, $urandom, $urandom, nw, 32'd0,
                     int'($urandom_range(0, 3)), -1);
        end

        // Both banks sized zero: block is taken but nothing is written.
        @(posedge clk); #2;
        i_enable = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        i_memory_0_size = 32'd0;
        i_memory_1_size = 32'd0;
        i_memory_0_new_data = 1'b1;
        i_memory_1_new_data = 1'b1;
        @(posedge clk); #2;
        i_memory_0_new_data = 1'b0;
        i_memory_1_new_data = 1'b0;
        blk.delete();
        for (int i = 0; i < 3; i++) blk.push_back(32'h7700 + 32'(i));
        rd_idx = 0;
        i_ppfifo_size = 24'd3;
        i_ppfifo_data = blk[0];
        act_seen = 0;
        cyc_seen = 0;
        pop_cnt = 0;
        i_ppfifo_rdy = 1'b1;
        i_enable = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        chk("zero_act_seen", 32'(act_seen), 32'd1);
        chk("zero_no_cyc", 32'(cyc_seen), 32'd0);
        chk("zero_no_pops", 32'(pop_cnt), 32'd0);
        chk("zero_full0", 32'(o_memory_0_full), 32'd1);
        chk("zero_full1", 32'(o_memory_1_full), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
